// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
//
// Parametrised multi-port register file for the decode/writeback path.
//   - NREAD combinational read ports, each returning register data and the
//     register's busy (pending-producer) bit.
//   - Two write ports; on an address collision port 1 wins.
//   - Per-register busy scoreboard: alloc_en marks a register busy, a write
//     retires it. Alloc and write to the same register on one edge leaves it
//     busy, because the alloc belongs to a newer producer.
//   - Clear engine: a clr_req pulse drops every busy bit at once, then zeroes
//     registers 1..DEPTH-1 one per cycle. Writes and allocs are discarded
//     while it runs.
//   - Register 0 is hardwired to zero and is never busy.
//
// Parameters
//   DATA_W  register width in bits
//   ADDR_W  address width, DEPTH = 2**ADDR_W
//   NREAD   number of read ports (>= 1)
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   we0/waddr0/wdata0     write port 0
//   we1/waddr1/wdata1     write port 1 (priority on collisions)
//   raddr                 packed read addresses, port k = [k*ADDR_W +: ADDR_W]
//   rdata                 packed read data,      port k = [k*DATA_W +: DATA_W]
//   rbusy                 busy bit of the register read by port k
//   alloc_en/alloc_addr   mark a register busy
//   clr_req               start the clear sequence (pulse, ignored while busy)
//   clr_busy              high while the clear sequence runs (DEPTH-1 cycles)
//
// Configuration
//   REGFILE_BYPASS_EN  when defined, a read that hits a write accepted in the
//                      same cycle returns the write data (port 1 preferred).
//                      Busy bits are never forwarded. When undefined, new
//                      data becomes visible the cycle after the write edge.
// -----------------------------------------------------------------------------
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREAD  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we0,
    input  logic [ADDR_W-1:0]       waddr0,
    input  logic [DATA_W-1:0]       wdata0,
    input  logic                    we1,
    input  logic [ADDR_W-1:0]       waddr1,
    input  logic [DATA_W-1:0]       wdata1,
    input  logic [NREAD*ADDR_W-1:0] raddr,
    output logic [NREAD*DATA_W-1:0] rdata,
    output logic [NREAD-1:0]        rbusy,
    input  logic                    alloc_en,
    input  logic [ADDR_W-1:0]       alloc_addr,
    input  logic                    clr_req,
    output logic                    clr_busy
);

    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;

    // -------------------------------------------------------------------------
    // Request qualification: traffic to register 0 and anything arriving
    // while the clear engine owns the array is dropped here, so the storage
    // and scoreboard logic below never has to re-check it.
    // -------------------------------------------------------------------------
    logic idle;
    logic wr0_ok;
    logic wr1_ok;
    logic alloc_ok;

    assign idle     = (state == ST_IDLE);
    assign wr0_ok   = idle && we0      && (waddr0     != '0);
    assign wr1_ok   = idle && we1      && (waddr1     != '0);
    assign alloc_ok = idle && alloc_en && (alloc_addr != '0);

    // -------------------------------------------------------------------------
    // Clear sequencer. The counter is loaded with 1 because register 0 never
    // holds anything but zero; the sequence ends after DEPTH-1 is cleared.
    // clr_busy is registered alongside the state so it tracks ST_CLEAR exactly.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            clr_cnt  <= '0;
            clr_busy <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clr_req) begin
                        state    <= ST_CLEAR;
                        clr_cnt  <= ADDR_W'(1);
                        clr_busy <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (clr_cnt == LAST_ADDR) begin
                        state    <= ST_IDLE;
                        clr_cnt  <= '0;
                        clr_busy <= 1'b0;
                    end else begin
                        clr_cnt  <= clr_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Register storage.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the array is reset element by element because zero-after-
            // reset is architectural here; a plain RAM must not be reset this
            // way, since it forces every storage bit onto the reset net.
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (state == ST_CLEAR) begin
            regs[clr_cnt] <= '0;
        end else begin
            if (wr0_ok) begin
                regs[waddr0] <= wdata0;
            end
            // NOTE: both ports use non-blocking assignments to the same array;
            // on a collision the later statement is the one that sticks, which
            // is what gives port 1 priority.
            if (wr1_ok) begin
                regs[waddr1] <= wdata1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Busy scoreboard. Order matters: writes retire first, then an alloc on
    // the same edge re-marks the register for its new producer. A clear
    // request overrides everything on its accepting edge.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else if (idle && clr_req) begin
            busy <= '0;
        end else begin
            if (wr0_ok) begin
                busy[waddr0] <= 1'b0;
            end
            if (wr1_ok) begin
                busy[waddr1] <= 1'b0;
            end
            if (alloc_ok) begin
                busy[alloc_addr] <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read ports. Entry 0 of the array is never written, but the explicit
    // zero keeps register 0 correct even if the forwarding path would match.
    // -------------------------------------------------------------------------
    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;

        assign ra = raddr[k*ADDR_W +: ADDR_W];

        // NOTE: rd is given a value on every path before any condition is
        // tested, so this combinational block can never infer a latch.
        always_comb begin
            rd = regs[ra];
`ifdef REGFILE_BYPASS_EN
            if (wr1_ok && (waddr1 == ra)) begin
                rd = wdata1;
            end else if (wr0_ok && (waddr0 == ra)) begin
                rd = wdata0;
            end
`endif
            if (ra == '0) begin
                rd = '0;
            end
        end

        assign rdata[k*DATA_W +: DATA_W] = rd;
        assign rbusy[k]                  = busy[ra];
    end

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
//
// Scoreboard bench for regfile_mp. The stimulus process drives one cycle of
// inputs, asks the reference model what the read ports must show in that
// cycle, queues the expectation, then advances the model across the edge.
// A separate monitor pops one expectation per cycle on the falling edge and
// compares every read port, every busy bit and clr_busy.
//
// The reference model is a plain array plus a count of clear cycles left;
// the register being cleared is derived from that count arithmetically.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREAD  = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    logic                    clk;
    logic                    rst;
    logic                    we0;
    logic [ADDR_W-1:0]       waddr0;
    logic [DATA_W-1:0]       wdata0;
    logic                    we1;
    logic [ADDR_W-1:0]       waddr1;
    logic [DATA_W-1:0]       wdata1;
    logic [NREAD*ADDR_W-1:0] raddr;
    logic [NREAD*DATA_W-1:0] rdata;
    logic [NREAD-1:0]        rbusy;
    logic                    alloc_en;
    logic [ADDR_W-1:0]       alloc_addr;
    logic                    clr_req;
    logic                    clr_busy;

    regfile_mp #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .NREAD (NREAD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .we0       (we0),
        .waddr0    (waddr0),
        .wdata0    (wdata0),
        .we1       (we1),
        .waddr1    (waddr1),
        .wdata1    (wdata1),
        .raddr     (raddr),
        .rdata     (rdata),
        .rbusy     (rbusy),
        .alloc_en  (alloc_en),
        .alloc_addr(alloc_addr),
        .clr_req   (clr_req),
        .clr_busy  (clr_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- model
    logic [DATA_W-1:0] m_regs [DEPTH];
    bit                m_busy [DEPTH];
    int                clr_remaining;

    typedef struct {
        logic [NREAD*DATA_W-1:0] rdata;
        logic [NREAD-1:0]        rbusy;
        logic                    clr_busy;
        string                   tag;
    } exp_t;

    exp_t sb_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(string name, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] model_read(logic [ADDR_W-1:0] a);
        if (a == '0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (clr_remaining == 0) begin
            if (we1 && waddr1 == a) return wdata1;
            if (we0 && waddr0 == a) return wdata0;
        end
`endif
        return m_regs[a];
    endfunction

    // Applies the inputs present at the edge to the model.
    task automatic model_update();
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
            end
            clr_remaining = 0;
        end else if (clr_remaining > 0) begin
            m_regs[DEPTH - clr_remaining] = '0;
            clr_remaining--;
        end else begin
            if (we0 && waddr0 != '0) begin
                m_regs[waddr0] = wdata0;
                m_busy[waddr0] = 1'b0;
            end
            if (we1 && waddr1 != '0) begin
                m_regs[waddr1] = wdata1;
                m_busy[waddr1] = 1'b0;
            end
            if (alloc_en && alloc_addr != '0) m_busy[alloc_addr] = 1'b1;
            if (clr_req) begin
                for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
                clr_remaining = DEPTH - 1;
            end
        end
    endtask

    task automatic push_expect(string tag);
        exp_t              e;
        logic [ADDR_W-1:0] a;
        e.tag = tag;
        for (int k = 0; k < NREAD; k++) begin
            a = raddr[k*ADDR_W +: ADDR_W];
            e.rdata[k*DATA_W +: DATA_W] = model_read(a);
            e.rbusy[k] = (a != '0) && m_busy[a];
        end
        e.clr_busy = (clr_remaining > 0);
        sb_q.push_back(e);
    endtask

    // ---------------------------------------------------------------- monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                for (int k = 0; k < NREAD; k++) begin
                    check($sformatf("%s rdata%0d", e.tag, k),
                          rdata[k*DATA_W +: DATA_W], e.rdata[k*DATA_W +: DATA_W]);
                    check($sformatf("%s rbusy%0d", e.tag, k),
                          DATA_W'(rbusy[k]), DATA_W'(e.rbusy[k]));
                end
                check($sformatf("%s clr_busy", e.tag), DATA_W'(clr_busy), DATA_W'(e.clr_busy));
            end
        end
    end

    // ---------------------------------------------------------------- helpers
    task automatic set_raddr(int k, logic [ADDR_W-1:0] a);
        raddr[k*ADDR_W +: ADDR_W] = a;
    endtask

    function automatic logic [ADDR_W-1:0] rand_addr();
        if ($urandom_range(0, 1) == 0) return ADDR_W'($urandom_range(0, 7));
        return ADDR_W'($urandom_range(0, DEPTH - 1));
    endfunction

    // One clock: queue expectation for this cycle, cross the edge, idle pulses.
    task automatic step(string tag);
        push_expect(tag);
        @(posedge clk);
        model_update();
        #1;
        we0      = 1'b0;
        we1      = 1'b0;
        alloc_en = 1'b0;
        clr_req  = 1'b0;
        rst      = 1'b0;
    endtask

    task automatic rand_inputs(bit allow_clr, bit allow_rst);
        we0        = ($urandom_range(0, 1) == 1);
        waddr0     = rand_addr();
        wdata0     = $urandom;
        we1        = ($urandom_range(0, 1) == 1);
        waddr1     = rand_addr();
        wdata1     = $urandom;
        alloc_en   = ($urandom_range(0, 2) == 0);
        alloc_addr = rand_addr();
        clr_req    = allow_clr && ($urandom_range(0, 63) == 0);
        rst        = allow_rst && ($urandom_range(0, 299) == 0);
        for (int k = 0; k < NREAD; k++) set_raddr(k, rand_addr());
    endtask

    task automatic fill_all(logic [DATA_W-1:0] v);
        for (int i = 1; i < DEPTH; i += 2) begin
            we0 = 1'b1; waddr0 = ADDR_W'(i); wdata0 = v;
            if (i + 1 < DEPTH) begin
                we1 = 1'b1; waddr1 = ADDR_W'(i + 1); wdata1 = v;
            end
            step("fill");
        end
    endtask

    task automatic read_all(string tag);
        for (int i = 0; i < DEPTH; i += NREAD) begin
            for (int k = 0; k < NREAD; k++) set_raddr(k, ADDR_W'((i + k) % DEPTH));
            step(tag);
        end
    endtask

    // ---------------------------------------------------------------- watchdog
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------------------------------------------------------- stimulus
    initial begin
        int hi;

        rst = 1'b1; we0 = 1'b0; we1 = 1'b0; alloc_en = 1'b0; clr_req = 1'b0;
        waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0; alloc_addr = '0;
        raddr = '0;
        @(posedge clk);
        model_update();
        #1;
        rst = 1'b0;

        // Reset after random traffic: everything reads zero and idle.
        for (int c = 0; c < 20; c++) begin
            rand_inputs(1'b0, 1'b0);
            step("pre-reset traffic");
        end
        rst = 1'b1;
        step("reset edge");
        read_all("after reset");

        // Basic write/read and register 0.
        we0 = 1'b1; waddr0 = 5; wdata0 = 32'hDEAD_BEEF;
        step("write 5");
        set_raddr(0, 5); set_raddr(1, 0);
        we1 = 1'b1; waddr1 = 0; wdata1 = 32'h1;
        step("read 5 / write 0");
        set_raddr(0, 0); set_raddr(1, 5);
        step("read 0");

        // Same-address collision: port 1 wins.
        we0 = 1'b1; waddr0 = 7; wdata0 = 32'h11;
        we1 = 1'b1; waddr1 = 7; wdata1 = 32'h22;
        step("collide 7");
        set_raddr(0, 7); set_raddr(1, 7);
        step("read 7");

        // Busy scoreboard on register 3.
        alloc_en = 1'b1; alloc_addr = 3;
        set_raddr(0, 3); set_raddr(1, 4);
        step("alloc 3");
        step("busy 3");
        alloc_en = 1'b1; alloc_addr = 3;
        we0 = 1'b1; waddr0 = 3; wdata0 = 32'h3333_0001;
        step("alloc+write 3");
        step("still busy 3");
        we1 = 1'b1; waddr1 = 3; wdata1 = 32'h3333_0002;
        step("retire 3");
        step("free 3");

        // Full clear sequence with traffic dropped during the window.
        fill_all(32'hFFFF_FFFF);
        clr_req = 1'b1;
        step("clr_req");
        hi = 0;
        for (int c = 0; c < 64; c++) begin
            if (!clr_busy) break;
            hi++;
            rand_inputs(1'b1, 1'b0);
            step("clear window");
        end
        check("clear length", DATA_W'(hi), DATA_W'(DEPTH - 1));
        read_all("after clear");

        // Reset part-way through a clear aborts it.
        fill_all(32'hFFFF_FFFF);
        clr_req = 1'b1;
        step("clr_req 2");
        for (int c = 0; c < 10; c++) begin
            rand_inputs(1'b0, 1'b0);
            step("partial clear");
        end
        rst = 1'b1;
        step("reset mid-clear");
        check("clr_busy after abort", DATA_W'(clr_busy), '0);
        read_all("after abort");

        // Same-cycle read of a register being written (forwarding if enabled).
        we0 = 1'b1; waddr0 = 9; wdata0 = 32'h1234_5678;
        step("seed 9");
        we1 = 1'b1; waddr1 = 9; wdata1 = 32'hA5A5_A5A5;
        set_raddr(0, 9); set_raddr(1, 9);
        step("same-cycle read 9");
        step("read 9 after");

        // Randomised traffic, including occasional clears and resets.
        for (int c = 0; c < 1500; c++) begin
            rand_inputs(1'b1, 1'b1);
            step("random");
        end

        repeat (3) @(negedge clk);
        check("scoreboard drained", DATA_W'(sb_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
